sgf_norm_round: RTL and testbench

SGF_NORM_ROUND -- requirements
Module: sgf_norm_round

---
 rtl/sgf_norm_round.sv | 131 +++++++++++++
 tb/tb_sgf_norm_round.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sgf_norm_round.sv
// Normalizes and rounds the raw KOA significand product to an MW-bit significand.
// Latency: 2 cycles (S1 input register, S2 result register), 1 result per cycle.
// Backpressure: elastic; S2 holds while ready_i is low, S1 refills in the same cycle S2 drains.
module sgf_norm_round #(
    parameter int SW = 54
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2*SW-1:0] sgf_result_i,
    input  logic            sign_i,
    input  logic [1:0]      round_mode_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [SW-2:0]   sgf_o,
    output logic            exp_adj_o,
    output logic            inexact_o,
    output logic            zero_o
);

    localparam int MW = SW - 1;
    localparam int PW = 2 * MW;

    localparam logic [1:0] RM_RNE  = 2'b00;
    localparam logic [1:0] RM_RTZ  = 2'b01;
    localparam logic [1:0] RM_PINF = 2'b10;
    localparam logic [1:0] RM_NINF = 2'b11;

    logic          s1_vld;
    logic [PW-1:0] s1_prod;
    logic          s1_sign;
    logic [1:0]    s1_mode;

    logic          s2_vld;
    logic [MW-1:0] s2_sgf;
    logic          s2_exp_adj;
    logic          s2_inexact;
    logic          s2_zero;

    logic          s2_adv;

    // The KOA output is two bits wider than the significand product.
    logic          unused_hi;
    assign unused_hi = ^sgf_result_i[2*SW-1:PW];

    assign s2_adv  = s1_vld && (!s2_vld || ready_i);
    assign ready_o = !rst && (!s1_vld || s2_adv);

    // Normalize / round datapath on the S1 contents.
    logic          nr_shift;
    logic [MW-1:0] nr_kept;
    logic          nr_guard;
    logic          nr_sticky;
    logic          nr_round_up;
    logic [MW:0]   nr_sum;
    logic          nr_carry;
    logic [MW-1:0] nr_sgf;
    logic          nr_zero;

    always_comb begin
        nr_shift = s1_prod[PW-1];
        if (nr_shift) begin
            nr_kept   = s1_prod[PW-1:MW];
            nr_guard  = s1_prod[MW-1];
            nr_sticky = |s1_prod[MW-2:0];
        end else begin
            nr_kept   = s1_prod[PW-2:MW-1];
            nr_guard  = s1_prod[MW-2];
            nr_sticky = |s1_prod[MW-3:0];
        end
    end

    always_comb begin
        nr_round_up = 1'b0;
        case (s1_mode)
            RM_RNE:  nr_round_up = nr_guard && (nr_sticky || nr_kept[0]);
            RM_RTZ:  nr_round_up = 1'b0;
            RM_PINF: nr_round_up = !s1_sign && (nr_guard || nr_sticky);
            RM_NINF: nr_round_up = s1_sign && (nr_guard || nr_sticky);
            default: nr_round_up = 1'b0;
        endcase
    end

    // A carry out of an all-ones significand renormalizes to 1.000...0.
    always_comb begin
        nr_sum   = {1'b0, nr_kept} + {{MW{1'b0}}, nr_round_up};
        nr_carry = nr_sum[MW];
        nr_sgf   = nr_carry ? {1'b1, {(MW-1){1'b0}}} : nr_sum[MW-1:0];
        nr_zero  = (s1_prod == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld     <= 1'b0;
            s1_prod    <= '0;
            s1_sign    <= 1'b0;
            s1_mode    <= 2'b00;
            s2_vld     <= 1'b0;
            s2_sgf     <= '0;
            s2_exp_adj <= 1'b0;
            s2_inexact <= 1'b0;
            s2_zero    <= 1'b0;
        end else begin
            if (ready_o) begin
                s1_vld <= valid_i;
                if (valid_i) begin
                    s1_prod <= sgf_result_i[PW-1:0];
                    s1_sign <= sign_i;
                    s1_mode <= round_mode_i;
                end
            end
            if (s2_adv) begin
                s2_vld     <= 1'b1;
                s2_sgf     <= nr_sgf;
                s2_exp_adj <= nr_shift || nr_carry;
                s2_inexact <= nr_guard || nr_sticky;
                s2_zero    <= nr_zero;
            end else if (ready_i) begin
                s2_vld <= 1'b0;
            end
        end
    end

    assign valid_o   = s2_vld;
    assign sgf_o     = s2_sgf;
    assign exp_adj_o = s2_exp_adj;
    assign inexact_o = s2_inexact;
    assign zero_o    = s2_zero;

endmodule

// File: tb/tb_sgf_norm_round.sv
// Directed-vector bench for sgf_norm_round (SW=54): rounding table, streaming, backpressure, reset.
module tb_sgf_norm_round;

    localparam int SW = 54;
    localparam int MW = SW - 1;

    localparam logic [1:0] RNE  = 2'b00;
    localparam logic [1:0] RTZ  = 2'b01;
    localparam logic [1:0] PINF = 2'b10;
    localparam logic [1:0] NINF = 2'b11;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [2*SW-1:0] sgf_result_i = '0;
    logic            sign_i = 1'b0;
    logic [1:0]      round_mode_i = 2'b00;
    logic            valid_o;
    logic            ready_i = 1'b0;
    logic [MW-1:0]   sgf_o;
    logic            exp_adj_o;
    logic            inexact_o;
    logic            zero_o;

    sgf_norm_round #(.SW(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .sgf_result_i (sgf_result_i),
        .sign_i       (sign_i),
        .round_mode_i (round_mode_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .sgf_o        (sgf_o),
        .exp_adj_o    (exp_adj_o),
        .inexact_o    (inexact_o),
        .zero_o       (zero_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*SW-1:0] prod;
        logic            sign;
        logic [1:0]      mode;
        logic [MW-1:0]   sgf;
        logic            adj;
        logic            inex;
        logic            zero;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    int n_pass = 0;
    int n_chk  = 0;

    function automatic vec_t mk(input logic [2*SW-1:0] prod, input logic sign, input logic [1:0] mode,
                                input logic [MW-1:0] sgf, input logic adj, input logic inex, input logic zero);
        vec_t v;
        v.prod = prod; v.sign = sign; v.mode = mode;
        v.sgf = sgf; v.adj = adj; v.inex = inex; v.zero = zero;
        return v;
    endfunction

    function automatic logic [63:0] exp_pack(input vec_t v);
        return {8'h0, v.sgf, v.adj, v.inex, v.zero};
    endfunction

    function automatic logic [63:0] out_pack();
        return {8'h0, sgf_o, exp_adj_o, inexact_o, zero_o};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, req);
    endtask

    task automatic drive(input vec_t v);
        sgf_result_i = v.prod;
        sign_i       = v.sign;
        round_mode_i = v.mode;
    endtask

    // One product through an otherwise empty pipeline with ready_i held high.
    task automatic send_check(input int idx);
        int w;
        int lat;
        @(negedge clk);
        drive(tbl[idx]);
        valid_i = 1'b1;
        ready_i = 1'b1;
        #1;
        w = 0;
        while (!ready_o && w < 20) begin
            @(negedge clk); #1; w++;
        end
        chk($sformatf("accept[%0d]", idx), {63'd0, ready_o}, 64'd1);
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        lat = 1;
        while (!valid_o && lat < 10) begin
            @(negedge clk); #1; lat++;
        end
        chk($sformatf("latency[%0d]", idx), lat, 64'd2);
        chk($sformatf("result[%0d]", idx), out_pack(), exp_pack(tbl[idx]));
    endtask

    // Four products offered back to back; ready_i held low for the first 'stall' cycles.
    task automatic run_stream(input int stall, input int base);
        int in_idx;
        int out_idx;
        in_idx  = 0;
        out_idx = 0;
        for (int c = 0; c < 40 && out_idx < 4; c++) begin
            @(negedge clk);
            ready_i = (c >= stall);
            if (in_idx < 4) begin
                drive(tbl[base + in_idx]);
                valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            #1;
            if (valid_o) begin
                chk($sformatf("stream%0d_out[%0d]", stall, out_idx), out_pack(), exp_pack(tbl[base + out_idx]));
                if (ready_i) out_idx++;
            end
            if (stall == 0 && valid_i) chk("no_bubble", {63'd0, ready_o}, 64'd1);
            if (valid_i && ready_o) in_idx++;
            if (stall > 0 && c == stall - 1) begin
                chk("bp_accepted", in_idx, 64'd2);
                chk("bp_ready_low", {63'd0, ready_o}, 64'd0);
            end
        end
        chk($sformatf("stream%0d_done", stall), out_idx, 64'd4);
        valid_i = 1'b0;
    endtask

    initial begin
        logic [2*SW-1:0] one;
        logic [2*SW-1:0] carry_p;
        one     = 108'd1;
        carry_p = (((one << 53) - one) << 52) | (one << 51);

        tbl[0]  = mk(one << 104,                          0, RNE,  53'h10000000000000, 0, 0, 0);
        tbl[1]  = mk((one << 105) | (one << 102),         0, RNE,  53'h12000000000000, 1, 0, 0);
        tbl[2]  = mk(carry_p,                             0, RNE,  53'h10000000000000, 1, 1, 0);
        tbl[3]  = mk(carry_p,                             0, RTZ,  53'h1FFFFFFFFFFFFF, 0, 1, 0);
        tbl[4]  = mk((one << 104) | one,                  0, PINF, 53'h10000000000001, 0, 1, 0);
        tbl[5]  = mk((one << 104) | one,                  1, PINF, 53'h10000000000000, 0, 1, 0);
        tbl[6]  = mk((one << 104) | one,                  1, NINF, 53'h10000000000001, 0, 1, 0);
        tbl[7]  = mk((one << 104) | one,                  0, NINF, 53'h10000000000000, 0, 1, 0);
        tbl[8]  = mk((one << 104) | one,                  0, RNE,  53'h10000000000000, 0, 1, 0);
        tbl[9]  = mk('0,                                  0, PINF, 53'h0,              0, 0, 1);
        tbl[10] = mk('0,                                  1, NINF, 53'h0,              0, 0, 1);
        tbl[11] = mk((one << 104) | (one << 51),          0, RNE,  53'h10000000000000, 0, 1, 0);
        tbl[12] = mk((one << 104) | (one << 52) | (one << 51), 0, RNE, 53'h10000000000002, 0, 1, 0);
        tbl[13] = mk((one << 105) | (one << 52),          0, RNE,  53'h10000000000000, 1, 1, 0);
        tbl[14] = mk((one << 105) | (one << 52),          0, PINF, 53'h10000000000001, 1, 1, 0);
        tbl[15] = mk(one << 60,                           0, RNE,  53'h100,            0, 0, 0);
        tbl[16] = mk((one << 107) | (one << 106) | (one << 104), 0, RNE, 53'h10000000000000, 0, 0, 0);
        tbl[17] = mk(carry_p,                             0, PINF, 53'h10000000000000, 1, 1, 0);

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready_low", {63'd0, ready_o}, 64'd0);
        chk("rst_valid_low", {63'd0, valid_o}, 64'd0);
        chk("rst_outputs",   out_pack(), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {63'd0, ready_o}, 64'd1);

        for (int i = 0; i < NV; i++) send_check(i);

        run_stream(0, 4);
        run_stream(4, 0);

        // Reset with both stages full: flushed products must never emerge.
        @(negedge clk);
        ready_i = 1'b0;
        drive(tbl[12]);
        valid_i = 1'b1;
        repeat (2) @(negedge clk);
        valid_i = 1'b0;
        #1;
        chk("flush_prefill_vld", {63'd0, valid_o}, 64'd1);
        chk("flush_prefill_full", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(tbl[13]);
        valid_i = 1'b1;
        #1;
        chk("rst_blocks_ready", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        #1;
        chk("flush_valid_low", {63'd0, valid_o}, 64'd0);
        chk("flush_outputs",   out_pack(), 64'd0);
        chk("flush_ready",     {63'd0, ready_o}, 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            chk("flushed_absent", {63'd0, valid_o}, 64'd0);
        end
        send_check(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
